// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer : records live pitch as (pitch, duration) segments, replays them
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module note_sequencer #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               pitch_in,
  input  logic                     rec_start,
  input  logic                     play_start,
  input  logic                     stop,
  output logic [4:0]               pitch_out,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   seq_len,
  output logic                     full,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 5 + DUR_W;
  localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_LAST_SLOT = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] C_TICK_MAX  = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    PLOAD = 2'd2,
    PHOLD = 2'd3
  } state_t;

  state_t            st;
  logic [CW-1:0]     tick_cnt;
  logic [4:0]        cur_pitch;
  logic [DUR_W-1:0]  dur;
  logic [DUR_W-1:0]  rem;
  logic [AW-1:0]     idx;
  logic              ld_ready;
  logic [EW-1:0]     rd_data;
  logic [EW-1:0]     mem [DEPTH];

  logic tick;
  logic changed;
  logic wr_en;
  logic last_entry;

  assign state      = st;
  assign full       = (seq_len == C_DEPTH);
  assign tick       = (tick_cnt == C_TICK_MAX);
  assign changed    = (pitch_in != cur_pitch);
  assign wr_en      = (st == REC) && (stop ? !full : changed);
  assign last_entry = ((AW+1)'(idx) == seq_len - 1'b1);

  // Buffer has no reset; a registered read gives one cycle of data latency in PLOAD.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[seq_len[AW-1:0]] <= {cur_pitch, dur};
    end
    rd_data <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      pitch_out <= '0;
      seq_len   <= '0;
      done      <= 1'b0;
      tick_cnt  <= '0;
      cur_pitch <= '0;
      dur       <= '0;
      rem       <= '0;
      idx       <= '0;
      ld_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == IDLE || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      case (st)
        IDLE: begin
          pitch_out <= pitch_in;
          if (stop) begin
            st <= IDLE;
          end else if (rec_start) begin
            st        <= REC;
            seq_len   <= '0;
            cur_pitch <= pitch_in;
            dur       <= '0;
          end else if (play_start) begin
            if (seq_len == '0) begin
              done <= 1'b1;
            end else begin
              st       <= PLOAD;
              idx      <= '0;
              ld_ready <= 1'b0;
            end
          end
        end

        REC: begin
          pitch_out <= pitch_in;
          if (stop) begin
            if (!full) seq_len <= seq_len + 1'b1;
            st       <= IDLE;
            tick_cnt <= '0;
          end else if (changed) begin
            // A tick coinciding with a pitch change is dropped with the old segment.
            seq_len   <= seq_len + 1'b1;
            cur_pitch <= pitch_in;
            dur       <= '0;
            if (seq_len == C_LAST_SLOT) begin
              st       <= IDLE;
              tick_cnt <= '0;
            end
          end else if (tick && dur != '1) begin
            dur <= dur + 1'b1;
          end
        end

        PLOAD, PHOLD: begin
          if (stop) begin
            pitch_out <= '0;
            done      <= 1'b1;
            st        <= IDLE;
            tick_cnt  <= '0;
          end else if (st == PLOAD) begin
            if (!ld_ready) begin
              ld_ready <= 1'b1;
            end else begin
              pitch_out <= rd_data[EW-1 -: 5];
              rem       <= rd_data[DUR_W-1:0];
              ld_ready  <= 1'b0;
              st        <= PHOLD;
            end
          end else if (rem == '0) begin
            if (last_entry) begin
              pitch_out <= '0;
              done      <= 1'b1;
              st        <= IDLE;
              tick_cnt  <= '0;
            end else begin
              idx <= idx + 1'b1;
              st  <= PLOAD;
            end
          end else if (tick) begin
            rem <= rem - 1'b1;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer : directed scoreboard bench for note_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_note_sequencer;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  pitch_in;
  logic        rec_start;
  logic        play_start;
  logic        stop;
  logic [4:0]  pitch_out;
  logic [1:0]  state;
  logic [2:0]  seq_len;
  logic        full;
  logic        done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int n;

  note_sequencer #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pitch_in   (pitch_in),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .pitch_out  (pitch_out),
    .state      (state),
    .seq_len    (seq_len),
    .full       (full),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Live forwarding: expected pitch queued when driven, compared one edge later.
  task automatic live(input int p);
    int e;
    pitch_in = 5'(p);
    exp_q.push_back(p);
    step();
    e = exp_q.pop_front();
    chk("live_pitch", pitch_out, e);
  endtask

  task automatic start_play();
    play_start = 1'b1;
    step();
    play_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pitch_in = '0; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_pitch", pitch_out, 0);
    chk("rst_seq_len", seq_len, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);

    // Empty playback
    start_play();
    chk("empty_done", done, 1);
    chk("empty_state", state, 0);
    step();
    chk("empty_done_clr", done, 0);

    // stop outranks rec_start in IDLE
    stop = 1'b1; rec_start = 1'b1;
    step();
    stop = 1'b0; rec_start = 1'b0;
    chk("stop_over_rec", state, 0);

    // Basic record, rec_start together with play_start
    pitch_in = 5'd8; rec_start = 1'b1; play_start = 1'b1;
    exp_q.push_back(8);
    step();
    rec_start = 1'b0; play_start = 1'b0;
    chk("rec_live0", pitch_out, exp_q.pop_front());
    chk("rec_over_play", state, 1);
    chk("rec_seq_len0", seq_len, 0);
    repeat (12) live(8);
    repeat (8) live(0);
    chk("rec_one_write", seq_len, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("rec_seq_len", seq_len, 2);
    chk("rec_state_idle", state, 0);
    chk("rec_full", full, 0);

    // Playback: {8,3} then {0,2}
    exp_q.push_back(8);
    exp_q.push_back(0);
    start_play();
    chk("play_pload", state, 2);
    step();
    chk("play_hold_prev", pitch_out, 0);
    step();
    chk("play_first_pitch", pitch_out, exp_q.pop_front());
    chk("play_phold", state, 3);
    n = 0;
    do begin step(); n++; end while (pitch_out == 5'd8 && n < 100);
    chk_range("play_hold8", n, 3*TICK_DIV - TICK_DIV, 3*TICK_DIV + TICK_DIV + 3);
    chk("play_second_pitch", pitch_out, exp_q.pop_front());
    chk("play_second_phold", state, 3);
    n = 0;
    do begin step(); n++; end while (!done && n < 100);
    chk_range("play_hold0", n, 2*TICK_DIV - TICK_DIV, 2*TICK_DIV + TICK_DIV + 3);
    chk("play_done", done, 1);
    chk("play_end_state", state, 0);
    chk("play_end_pitch", pitch_out, 0);
    step();
    chk("play_done_pulse", done, 0);
    chk("play_seq_len_kept", seq_len, 2);

    // Stop mid-playback, then restart from entry 0
    start_play();
    step(); step();
    chk("stopplay_pitch", pitch_out, 8);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stopplay_pitch0", pitch_out, 0);
    chk("stopplay_done", done, 1);
    chk("stopplay_state", state, 0);
    step();
    chk("stopplay_done_clr", done, 0);
    start_play();
    step();
    chk("restart_hold_prev", pitch_out, 0);
    step();
    chk("restart_entry0", pitch_out, 8);

    // Reset during PHOLD
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_pitch", pitch_out, 0);
    chk("midrst_seq_len", seq_len, 0);
    chk("midrst_done", done, 0);

    // Overflow: changes to 1..5 spaced 8 cycles apart
    pitch_in = '0; rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      live(k);
      if (k == 3) begin
        chk("ovf_len3", seq_len, 3);
        chk("ovf_notfull", full, 0);
        chk("ovf_still_rec", state, 1);
      end
      if (k == 4) begin
        chk("ovf_len4", seq_len, 4);
        chk("ovf_full", full, 1);
        chk("ovf_idle", state, 0);
      end
      if (k == 5) begin
        chk("ovf_ignored", seq_len, 4);
        chk("ovf_ignored_state", state, 0);
      end
      repeat (7) live(k);
    end

    // Duration saturation at 2^DUR_W-1 ticks
    pitch_in = 5'd3; rec_start = 1'b1;
    step();
    rec_start = 1'b0;
    repeat (1100) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_seq_len", seq_len, 1);
    start_play();
    step(); step();
    chk("sat_pitch", pitch_out, 3);
    n = 0;
    do begin step(); n++; end while (pitch_out == 5'd3 && n < 2000);
    chk_range("sat_hold", n, 255*TICK_DIV - TICK_DIV, 255*TICK_DIV + TICK_DIV + 3);
    chk("sat_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
